// File: rtl/hack_exec_ctrl_if.sv
// Bus bundle between the Hack execution controller and its environment:
// instruction handshake, ALU operand/result path and data-memory port.
interface hack_exec_ctrl_if #(
  parameter int unsigned PC_W   = 15,
  parameter int unsigned WORD_W = 16
);
  logic              instr_valid;
  logic              instr_ready;
  logic [WORD_W-1:0] instr;

  logic [WORD_W-1:0] alu_x;
  logic [WORD_W-1:0] alu_y;
  logic              alu_zx;
  logic              alu_nx;
  logic              alu_zy;
  logic              alu_ny;
  logic              alu_f;
  logic              alu_no;
  logic [WORD_W-1:0] alu_out;
  logic              alu_zr;
  logic              alu_ng;

  logic              m_rd_en;
  logic [PC_W-1:0]   m_addr;
  logic [WORD_W-1:0] m_rd_data;
  logic              m_wr_en;
  logic [WORD_W-1:0] m_wr_data;

  // Controller side
  modport slave (
    input  instr_valid, instr, alu_out, alu_zr, alu_ng, m_rd_data,
    output instr_ready, alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny,
           alu_f, alu_no, m_rd_en, m_addr, m_wr_en, m_wr_data
  );

  // Environment side (instruction source, ALU, data memory)
  modport master (
    output instr_valid, instr, alu_out, alu_zr, alu_ng, m_rd_data,
    input  instr_ready, alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny,
           alu_f, alu_no, m_rd_en, m_addr, m_wr_en, m_wr_data
  );
endinterface

// File: rtl/hack_exec_ctrl.sv
// Hack CPU execution controller: accepts instructions, holds A/D/pc,
// fetches M, drives the external ALU and resolves writeback and jumps.
module hack_exec_ctrl #(
  parameter int unsigned PC_W   = 15,
  parameter int unsigned WORD_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  hack_exec_ctrl_if.slave   bus,
  output logic [PC_W-1:0]   pc,
  output logic              jump,
  output logic [WORD_W-1:0] a_reg,
  output logic [WORD_W-1:0] d_reg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MREAD = 2'd1,
    EXEC  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] d_q, d_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [12:0]       ir_q, ir_d;
  logic [WORD_W-1:0] m_q, m_d;
  logic [WORD_W-1:0] x_hold_q, x_hold_d;
  logic [WORD_W-1:0] y_hold_q, y_hold_d;
  logic [5:0]        ctl_hold_q, ctl_hold_d;

  logic              ready;
  logic              rd_en;
  logic              wr_en;
  logic [WORD_W-1:0] wr_data;
  logic              jump_o;
  logic [WORD_W-1:0] x_o;
  logic [WORD_W-1:0] y_o;
  logic [5:0]        ctl_o;

  logic              c_a;
  logic [5:0]        c_ctl;
  logic              c_da, c_dd, c_dm;
  logic [2:0]        c_j;
  logic              taken;

  assign c_a   = ir_q[12];
  assign c_ctl = ir_q[11:6];
  assign c_da  = ir_q[5];
  assign c_dd  = ir_q[4];
  assign c_dm  = ir_q[3];
  assign c_j   = ir_q[2:0];

  assign taken = (c_j[2] & bus.alu_ng) |
                 (c_j[1] & bus.alu_zr) |
                 (c_j[0] & ~bus.alu_ng & ~bus.alu_zr);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    d_d        = d_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    m_d        = m_q;
    ready      = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    jump_o     = 1'b0;
    x_o        = x_hold_q;
    y_o        = y_hold_q;
    ctl_o      = ctl_hold_q;

    case (state_q)
      IDLE: begin
        ready = reset_n;
        if (bus.instr_valid && reset_n) begin
          ir_d = bus.instr[12:0];
          if (!bus.instr[15]) begin
            a_d              = '0;
            a_d[PC_W-1:0]    = bus.instr[PC_W-1:0];
            pc_d             = pc_q + PC_W'(1);
          end else begin
            state_d = bus.instr[12] ? MREAD : EXEC;
          end
        end
      end
      MREAD: begin
        rd_en   = 1'b1;
        m_d     = bus.m_rd_data;
        state_d = EXEC;
      end
      EXEC: begin
        x_o     = d_q;
        y_o     = c_a ? m_q : a_q;
        ctl_o   = c_ctl;
        wr_en   = c_dm;
        wr_data = c_dm ? bus.alu_out : '0;
        jump_o  = taken;
        // Jump target and write address both use A as it was before this edge.
        pc_d    = taken ? a_q[PC_W-1:0] : pc_q + PC_W'(1);
        if (c_da) a_d = bus.alu_out;
        if (c_dd) d_d = bus.alu_out;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Operands and controls persist at their EXEC values until the next EXEC.
    x_hold_d   = x_o;
    y_hold_d   = y_o;
    ctl_hold_d = ctl_o;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      d_q        <= '0;
      pc_q       <= '0;
      ir_q       <= '0;
      m_q        <= '0;
      x_hold_q   <= '0;
      y_hold_q   <= '0;
      ctl_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      d_q        <= d_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      m_q        <= m_d;
      x_hold_q   <= x_hold_d;
      y_hold_q   <= y_hold_d;
      ctl_hold_q <= ctl_hold_d;
    end
  end

  assign bus.instr_ready = ready;
  assign bus.alu_x       = x_o;
  assign bus.alu_y       = y_o;
  assign bus.alu_zx      = ctl_o[5];
  assign bus.alu_nx      = ctl_o[4];
  assign bus.alu_zy      = ctl_o[3];
  assign bus.alu_ny      = ctl_o[2];
  assign bus.alu_f       = ctl_o[1];
  assign bus.alu_no      = ctl_o[0];
  assign bus.m_rd_en     = rd_en;
  assign bus.m_addr      = a_q[PC_W-1:0];
  assign bus.m_wr_en     = wr_en;
  assign bus.m_wr_data   = wr_data;

  assign pc    = pc_q;
  assign jump  = jump_o;
  assign a_reg = a_q;
  assign d_reg = d_q;

endmodule

// File: tb/tb_hack_exec_ctrl.sv
// Self-checking bench for hack_exec_ctrl: environment ALU and memory,
// instruction-level reference model, directed and randomized stimulus.
module tb_hack_exec_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [14:0] pc;
  logic        jump;
  logic [15:0] a_reg;
  logic [15:0] d_reg;

  hack_exec_ctrl_if #(.PC_W(15), .WORD_W(16)) bus ();

  hack_exec_ctrl #(.PC_W(15), .WORD_W(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .pc      (pc),
    .jump    (jump),
    .a_reg   (a_reg),
    .d_reg   (d_reg)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_sent   = 0;
  int unsigned n_acc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Hack ALU: returns {zr, ng, out}
  function automatic logic [17:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0 : y;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? xx + yy : xx & yy;
    o  = c[0] ? ~o : o;
    return {(o == 16'h0), o[15], o};
  endfunction

  // Environment: ALU and data memory
  logic [15:0] env_mem   [0:32767];
  logic [15:0] model_mem [0:32767];

  assign {bus.alu_zr, bus.alu_ng, bus.alu_out} =
    hack_alu(bus.alu_x, bus.alu_y,
             {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no});
  assign bus.m_rd_data = bus.m_rd_en ? env_mem[bus.m_addr] : 16'h0;

  always @(posedge clock) begin
    if (bus.m_wr_en) env_mem[bus.m_addr] <= bus.m_wr_data;
  end

  // Instruction-level reference model: an instruction's effects are computed
  // at acceptance and become architecturally visible after its latency.
  logic [15:0] md_a = '0, md_d = '0;
  logic [14:0] md_pc = '0;
  int          rem = 0;
  logic [15:0] p_x, p_y, p_out;
  logic [5:0]  p_ctl;
  logic        p_da, p_dd, p_dm, p_jump;
  logic [15:0] last_x = '0, last_y = '0;
  logic [5:0]  last_ctl = '0;

  always @(posedge clock or negedge reset_n) begin
    logic [15:0] ins;
    logic [17:0] r;
    if (!reset_n) begin
      md_a = '0; md_d = '0; md_pc = '0; rem = 0;
      last_x = '0; last_y = '0; last_ctl = '0;
    end else if (rem != 0) begin
      rem--;
      if (rem == 0) begin
        if (p_dm) model_mem[md_a[14:0]] = p_out;
        md_pc = p_jump ? md_a[14:0] : md_pc + 15'd1;
        if (p_da) md_a = p_out;
        if (p_dd) md_d = p_out;
        last_x = p_x; last_y = p_y; last_ctl = p_ctl;
      end
    end else if (bus.instr_valid) begin
      ins = bus.instr;
      n_acc++;
      if (!ins[15]) begin
        md_a  = {1'b0, ins[14:0]};
        md_pc = md_pc + 15'd1;
      end else begin
        p_x    = md_d;
        p_y    = ins[12] ? model_mem[md_a[14:0]] : md_a;
        p_ctl  = ins[11:6];
        r      = hack_alu(p_x, p_y, p_ctl);
        p_out  = r[15:0];
        p_jump = (ins[2] & r[16]) | (ins[1] & r[17]) | (ins[0] & ~r[16] & ~r[17]);
        {p_da, p_dd, p_dm} = ins[5:3];
        rem    = ins[12] ? 2 : 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    logic in_rd, in_ex;
    in_rd = (rem == 2);
    in_ex = (rem == 1);
    chk("instr_ready", bus.instr_ready, (rem == 0) && reset_n);
    chk("pc", pc, md_pc);
    chk("a_reg", a_reg, md_a);
    chk("d_reg", d_reg, md_d);
    chk("m_rd_en", bus.m_rd_en, in_rd);
    chk("m_wr_en", bus.m_wr_en, in_ex && p_dm);
    chk("jump", jump, in_ex && p_jump);
    chk("m_addr", bus.m_addr, md_a[14:0]);
    chk("alu_x", bus.alu_x, in_ex ? p_x : last_x);
    chk("alu_y", bus.alu_y, in_ex ? p_y : last_y);
    chk("alu_ctl", {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no},
        in_ex ? p_ctl : last_ctl);
    if (in_ex && p_dm) chk("m_wr_data", bus.m_wr_data, p_out);
  end

  task automatic wait_ready(input string name);
    int unsigned n = 0;
    @(negedge clock);
    while (!bus.instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) chk(name, bus.instr_ready, 1);
  endtask

  // Present one instruction; returns #1 after the accepting edge
  task automatic send(input logic [15:0] w);
    wait_ready("send_timeout");
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    @(posedge clock);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0;
    n_sent++;
  endtask

  logic [15:0] q[$];
  logic [15:0] w;
  int unsigned pct, cyc, mem_bad;
  logic give, rdy;

  initial begin
    reset_n         = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0;
    for (int i = 0; i < 32768; i++) begin
      env_mem[i]   = 16'(i * 40503) ^ 16'h5A5A;
      model_mem[i] = 16'(i * 40503) ^ 16'h5A5A;
    end
    env_mem[5]   = 16'h0007;
    model_mem[5] = 16'h0007;

    repeat (3) @(negedge clock);
    chk("rst_pc", pc, 15'h0);
    chk("rst_ready", bus.instr_ready, 1'b0);
    chk("rst_alu_x", bus.alu_x, 16'h0);
    #2 reset_n = 1'b1;

    // @21 ; D=A
    send(16'h0015);
    send(16'hEC10);
    chk("dA_ctl", {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no}, 6'b110000);
    chk("dA_y", bus.alu_y, 16'h0015);
    wait_ready("idle1");
    chk("dA_a", a_reg, 16'h0015);
    chk("dA_d", d_reg, 16'h0015);
    chk("dA_pc", pc, 15'd2);

    // D=3, A=5, D=D+M with M[5]=7
    send(16'h0003); send(16'hEC10); send(16'h0005);
    send(16'hF090);
    chk("dm_rd_en", bus.m_rd_en, 1'b1);
    chk("dm_addr", bus.m_addr, 15'h0005);
    @(posedge clock); #1;
    chk("dm_y", bus.alu_y, 16'h0007);
    chk("dm_x", bus.alu_x, 16'h0003);
    wait_ready("idle2");
    chk("dm_d", d_reg, 16'h000A);

    // D=9, A=0x10, AM=D+1
    send(16'h0009); send(16'hEC10); send(16'h0010);
    send(16'hE7E8);
    chk("am_wr_en", bus.m_wr_en, 1'b1);
    chk("am_addr", bus.m_addr, 15'h0010);
    chk("am_wr_data", bus.m_wr_data, 16'h000A);
    wait_ready("idle3");
    chk("am_a", a_reg, 16'h000A);
    chk("am_mem", env_mem[16], 16'h000A);

    // D=-1, A=0x40, D;JLT taken ; D=0, D;JGT not taken
    send(16'hEE90); send(16'h0040);
    send(16'hE304);
    chk("jlt_jump", jump, 1'b1);
    wait_ready("idle4");
    chk("jlt_pc", pc, 15'h0040);
    send(16'hEA90);
    send(16'hE301);
    chk("jgt_jump", jump, 1'b0);
    wait_ready("idle5");
    chk("jgt_pc", pc, 15'h0042);

    // Jump to 0x7FFF then an A-instruction wraps pc
    send(16'h7FFF);
    send(16'hEA87);
    wait_ready("idle6");
    chk("wrap_pre", pc, 15'h7FFF);
    send(16'h0001);
    chk("wrap_pc", pc, 15'h0000);

    // Reset during EXEC of AM=D;JMP: nothing commits
    send(16'h0030);
    send(16'hE32F);
    chk("mid_wr_en", bus.m_wr_en, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_pc", pc, 15'h0);
    chk("mid_a", a_reg, 16'h0);
    chk("mid_d", d_reg, 16'h0);
    chk("mid_wr_en0", bus.m_wr_en, 1'b0);
    chk("mid_jump", jump, 1'b0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", bus.instr_ready, 1'b1);
    chk("mid_mem", env_mem[16'h0030], model_mem[16'h0030]);

    // Randomized stream: first part with instr_valid held high
    for (int i = 0; i < 600; i++) begin
      w = 16'($urandom());
      if ($urandom_range(0, 1) == 0) w[15] = 1'b0;
      else w[15] = 1'b1;
      q.push_back(w);
    end
    cyc = 0;
    while (q.size() != 0 && cyc < 20000) begin
      pct = (q.size() > 400) ? 100 : 60;
      @(negedge clock);
      give = ($urandom_range(0, 99) < pct);
      bus.instr_valid = give;
      bus.instr       = give ? q[0] : 16'($urandom());
      rdy = bus.instr_ready;
      @(posedge clock);
      #1;
      if (give && rdy) begin
        void'(q.pop_front());
        n_sent++;
      end
      cyc++;
    end
    bus.instr_valid = 1'b0;
    chk("stream_drained", q.size(), 0);
    wait_ready("idle_end");
    chk("accept_count", n_acc, n_sent);
    mem_bad = 0;
    for (int i = 0; i < 32768; i++) if (env_mem[i] !== model_mem[i]) mem_bad++;
    chk("mem_image", mem_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
